tx_controller: RTL and testbench

- Transmit-side flow-control engine for the RIFL lane; it is the peer-side counterpart of the receive controller that decodes PAUSE/RETRANS codes.
- Once per frame it chooses what the next frame carries: user data, or an 18-bit control code (header + 16-bit key). Control codes are PAUSE, RETRANS or IDLE.
- It sits between the local receive path (buffer-full, CRC error), the local decoded remote-pause flag, and the TX frame mux.

---
 rtl/tx_controller.sv | 181 ++++++++++++++++++
 tb/tb_tx_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_controller.sv
// rtl/tx_controller.sv - RIFL transmit-side flow-control engine
//
// Once per frame (at each sof strobe) decides whether the next frame carries
// user data or an 18-bit control code (PAUSE, RETRANS or IDLE), and drives
// the TX frame mux accordingly. Decisions made at the sof edge of frame N
// take effect for frame N+1.
//
// Ports:
//   clk               core clock
//   rst_n             asynchronous active-low reset
//   sof               one-cycle frame-boundary strobe
//   tx_aligned        TX lane up; low flushes back to NORMAL with idle frames
//   local_pause_req   level, local RX buffer almost full
//   local_retrans_req pulse, local RX saw an errored frame
//   remote_pause      level, peer asked us to stop sending data
//   code              [17:16] header, [15:0] key for the next frame
//   code_override     1 = mux sends code, 0 = mux sends user data
//   data_grant        user data may occupy the next frame
//   retrans_active    high while the RETRANS burst is being sent

module tx_controller #(
  parameter int CTRL_FRAMES    = 8,   // 8..31, saturates peer 4-bit detector
  parameter int RELEASE_FRAMES = 16   // 16..31, saturates peer 5-bit counter
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic        tx_aligned,
  input  logic        local_pause_req,
  input  logic        local_retrans_req,
  input  logic        remote_pause,
  output logic [17:0] code,
  output logic        code_override,
  output logic        data_grant,
  output logic        retrans_active
);

  localparam logic [1:0]  HDR_CTRL    = 2'b10;
  localparam logic [15:0] KEY_IDLE    = 16'h0001;
  localparam logic [15:0] KEY_PAUSE   = 16'h0010;
  localparam logic [15:0] KEY_RETRANS = 16'h1000;

  localparam logic [17:0] IDLE_FRAME    = {HDR_CTRL, KEY_IDLE};
  localparam logic [17:0] PAUSE_FRAME   = {HDR_CTRL, KEY_PAUSE};
  localparam logic [17:0] RETRANS_FRAME = {HDR_CTRL, KEY_RETRANS};

  localparam logic [4:0] CTRL_LAST = 5'(CTRL_FRAMES - 1);
  localparam logic [4:0] REL_LAST  = 5'(RELEASE_FRAMES - 1);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_PAUSE,
    ST_RETRANS,
    ST_RELEASE
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic        retrans_pending;
  logic        enter_retrans;
  logic [17:0] code_n;
  logic        override_n;
  logic        grant_n;
  logic        active_n;

  // Next-state, counter and next-frame output decode.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    code_n     = IDLE_FRAME;
    override_n = 1'b1;
    grant_n    = 1'b0;
    active_n   = 1'b0;

    if (!tx_aligned) begin
      state_n = ST_NORMAL;
      cnt_n   = 5'd0;
    end else begin
      unique case (state)
        ST_NORMAL: begin
          if (retrans_pending) begin
            state_n = ST_RETRANS;
            cnt_n   = 5'd0;
          end else if (local_pause_req) begin
            state_n = ST_PAUSE;
            cnt_n   = 5'd0;
          end
        end
        ST_PAUSE: begin
          if (retrans_pending) begin
            state_n = ST_RETRANS;
            cnt_n   = 5'd0;
          end else if (!local_pause_req && cnt >= CTRL_LAST) begin
            state_n = ST_RELEASE;
            cnt_n   = 5'd0;
          end else if (cnt != CNT_MAX) begin
            // Long pauses saturate rather than wrap so the minimum-burst
            // test above stays satisfied however long the pause lasts.
            cnt_n = cnt + 5'd1;
          end
        end
        ST_RETRANS: begin
          if (cnt == CTRL_LAST) begin
            state_n = ST_RELEASE;
            cnt_n   = 5'd0;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
        ST_RELEASE: begin
          if (retrans_pending) begin
            state_n = ST_RETRANS;
            cnt_n   = 5'd0;
          end else if (local_pause_req) begin
            state_n = ST_PAUSE;
            cnt_n   = 5'd0;
          end else if (cnt == REL_LAST) begin
            state_n = ST_NORMAL;
            cnt_n   = 5'd0;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
        default: begin
          state_n = ST_NORMAL;
          cnt_n   = 5'd0;
        end
      endcase
    end

    // Outputs describe the frame that follows this sof, i.e. the new state.
    unique case (state_n)
      ST_NORMAL: begin
        if (tx_aligned && !remote_pause) begin
          override_n = 1'b0;
          grant_n    = 1'b1;
        end
      end
      ST_PAUSE:   code_n = PAUSE_FRAME;
      ST_RETRANS: begin
        code_n   = RETRANS_FRAME;
        active_n = 1'b1;
      end
      default:    code_n = IDLE_FRAME;
    endcase
  end

  // Only a transition into RETRANS consumes the pending request; a pulse
  // that lands while RETRANS is already running stays pending and triggers
  // a second burst after the current one.
  assign enter_retrans = tx_aligned && (state != ST_RETRANS) && (state_n == ST_RETRANS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_NORMAL;
      cnt             <= 5'd0;
      retrans_pending <= 1'b0;
      code            <= IDLE_FRAME;
      code_override   <= 1'b1;
      data_grant      <= 1'b0;
      retrans_active  <= 1'b0;
    end else begin
      if (sof && enter_retrans) begin
        retrans_pending <= 1'b0;
      end else if (local_retrans_req) begin
        retrans_pending <= 1'b1;
      end

      if (sof) begin
        state          <= state_n;
        cnt            <= cnt_n;
        code           <= code_n;
        code_override  <= override_n;
        data_grant     <= grant_n;
        retrans_active <= active_n;
      end
    end
  end

endmodule

// File: tb/tb_tx_controller.sv
// tb/tb_tx_controller.sv - directed self-checking bench for tx_controller

module tb_tx_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof;
  logic        tx_aligned;
  logic        local_pause_req;
  logic        local_retrans_req;
  logic        remote_pause;
  logic [17:0] code;
  logic        code_override;
  logic        data_grant;
  logic        retrans_active;
  logic [20:0] obs;

  int errors = 0;
  int checks = 0;

  // {code, code_override, data_grant, retrans_active}
  localparam logic [20:0] EXP_RT = {18'h21000, 3'b101};
  localparam logic [20:0] EXP_PS = {18'h20010, 3'b100};
  localparam logic [20:0] EXP_ID = {18'h20001, 3'b100};
  localparam logic [20:0] EXP_GR = {18'h20001, 3'b010};

  tx_controller #(.CTRL_FRAMES(8), .RELEASE_FRAMES(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sof               (sof),
    .tx_aligned        (tx_aligned),
    .local_pause_req   (local_pause_req),
    .local_retrans_req (local_retrans_req),
    .remote_pause      (remote_pause),
    .code              (code),
    .code_override     (code_override),
    .data_grant        (data_grant),
    .retrans_active    (retrans_active)
  );

  assign obs = {code, code_override, data_grant, retrans_active};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One frame: sof for one cycle, then two quiet cycles; returns on a negedge.
  task automatic frame();
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_retrans();
    local_retrans_req = 1'b1;
    @(negedge clk);
    local_retrans_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sof = 1'b0;
    tx_aligned = 1'b1;
    local_pause_req = 1'b0;
    local_retrans_req = 1'b0;
    remote_pause = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== EXP_ID) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, EXP_ID);
    end
    rst_n = 1'b1;
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL reset_first_frame: got %h want %h", obs, EXP_GR);
    end
  endtask

  task automatic test_retrans();
    pulse_retrans();
    for (int i = 0; i < 8; i++) begin
      frame();
      checks++;
      if (obs !== EXP_RT) begin
        errors++;
        $display("FAIL retrans_burst frame %0d: got %h want %h", i, obs, EXP_RT);
      end
    end
    for (int i = 0; i < 16; i++) begin
      frame();
      checks++;
      if (obs !== EXP_ID) begin
        errors++;
        $display("FAIL retrans_release frame %0d: got %h want %h", i, obs, EXP_ID);
      end
    end
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL retrans_back_to_normal: got %h want %h", obs, EXP_GR);
    end
  endtask

  task automatic test_pause(input int hold);
    int total;
    total = (hold < 8) ? 8 : hold;
    local_pause_req = 1'b1;
    for (int i = 0; i < total; i++) begin
      if (i == hold) local_pause_req = 1'b0;
      frame();
      checks++;
      if (obs !== EXP_PS) begin
        errors++;
        $display("FAIL pause_burst hold %0d frame %0d: got %h want %h", hold, i, obs, EXP_PS);
      end
    end
    local_pause_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      frame();
      checks++;
      if (obs !== EXP_ID) begin
        errors++;
        $display("FAIL pause_release hold %0d frame %0d: got %h want %h", hold, i, obs, EXP_ID);
      end
    end
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL pause_back_to_normal hold %0d: got %h want %h", hold, obs, EXP_GR);
    end
  endtask

  task automatic test_pause_then_retrans();
    local_pause_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame();
      checks++;
      if (obs !== EXP_PS) begin
        errors++;
        $display("FAIL pr_pause frame %0d: got %h want %h", i, obs, EXP_PS);
      end
    end
    pulse_retrans();
    for (int i = 0; i < 8; i++) begin
      frame();
      if (i == 2) local_pause_req = 1'b0;
      checks++;
      if (obs !== EXP_RT) begin
        errors++;
        $display("FAIL pr_retrans frame %0d: got %h want %h", i, obs, EXP_RT);
      end
    end
    for (int i = 0; i < 10; i++) begin
      frame();
      checks++;
      if (obs !== EXP_ID) begin
        errors++;
        $display("FAIL pr_release frame %0d: got %h want %h", i, obs, EXP_ID);
      end
    end
    // Pause returns late in RELEASE: must re-enter PAUSE, not NORMAL.
    local_pause_req = 1'b1;
    frame();
    local_pause_req = 1'b0;
    checks++;
    if (obs !== EXP_PS) begin
      errors++;
      $display("FAIL pr_reenter_pause: got %h want %h", obs, EXP_PS);
    end
    for (int i = 1; i < 8; i++) begin
      frame();
      checks++;
      if (obs !== EXP_PS) begin
        errors++;
        $display("FAIL pr_pause2 frame %0d: got %h want %h", i, obs, EXP_PS);
      end
    end
    for (int i = 0; i < 16; i++) begin
      frame();
      checks++;
      if (obs !== EXP_ID) begin
        errors++;
        $display("FAIL pr_release2 frame %0d: got %h want %h", i, obs, EXP_ID);
      end
    end
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL pr_back_to_normal: got %h want %h", obs, EXP_GR);
    end
  endtask

  task automatic test_remote_pause();
    remote_pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frame();
      checks++;
      if (obs !== EXP_ID) begin
        errors++;
        $display("FAIL remote_pause frame %0d: got %h want %h", i, obs, EXP_ID);
      end
    end
    remote_pause = 1'b0;
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL remote_pause_release: got %h want %h", obs, EXP_GR);
    end
  endtask

  task automatic test_misaligned();
    local_pause_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame();
      checks++;
      if (obs !== EXP_PS) begin
        errors++;
        $display("FAIL mis_pause frame %0d: got %h want %h", i, obs, EXP_PS);
      end
    end
    // cnt is now 5 inside PAUSE.
    tx_aligned = 1'b0;
    frame();
    checks++;
    if (obs !== EXP_ID) begin
      errors++;
      $display("FAIL mis_flush: got %h want %h", obs, EXP_ID);
    end
    local_pause_req = 1'b0;
    pulse_retrans();
    frame();
    checks++;
    if (obs !== EXP_ID) begin
      errors++;
      $display("FAIL mis_hold_pending: got %h want %h", obs, EXP_ID);
    end
    tx_aligned = 1'b1;
    for (int i = 0; i < 8; i++) begin
      frame();
      checks++;
      if (obs !== EXP_RT) begin
        errors++;
        $display("FAIL mis_retrans frame %0d: got %h want %h", i, obs, EXP_RT);
      end
    end
    for (int i = 0; i < 16; i++) begin
      frame();
      checks++;
      if (obs !== EXP_ID) begin
        errors++;
        $display("FAIL mis_release frame %0d: got %h want %h", i, obs, EXP_ID);
      end
    end
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL mis_back_to_normal: got %h want %h", obs, EXP_GR);
    end
  endtask

  task automatic test_back_to_back();
    pulse_retrans();
    for (int i = 0; i < 8; i++) begin
      frame();
      if (i == 3) pulse_retrans();
      checks++;
      if (obs !== EXP_RT) begin
        errors++;
        $display("FAIL b2b_first frame %0d: got %h want %h", i, obs, EXP_RT);
      end
    end
    frame();
    checks++;
    if (obs !== EXP_ID) begin
      errors++;
      $display("FAIL b2b_gap: got %h want %h", obs, EXP_ID);
    end
    for (int i = 0; i < 8; i++) begin
      frame();
      checks++;
      if (obs !== EXP_RT) begin
        errors++;
        $display("FAIL b2b_second frame %0d: got %h want %h", i, obs, EXP_RT);
      end
    end
    for (int i = 0; i < 16; i++) begin
      frame();
      checks++;
      if (obs !== EXP_ID) begin
        errors++;
        $display("FAIL b2b_release frame %0d: got %h want %h", i, obs, EXP_ID);
      end
    end
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL b2b_back_to_normal: got %h want %h", obs, EXP_GR);
    end
  endtask

  task automatic test_reset_mid_retrans();
    pulse_retrans();
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++;
      if (obs !== EXP_RT) begin
        errors++;
        $display("FAIL rst_mid_retrans frame %0d: got %h want %h", i, obs, EXP_RT);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== EXP_ID) begin
      errors++;
      $display("FAIL rst_async_outputs: got %h want %h", obs, EXP_ID);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    frame();
    checks++;
    if (obs !== EXP_GR) begin
      errors++;
      $display("FAIL rst_after_release: got %h want %h", obs, EXP_GR);
    end
  endtask

  initial begin
    test_reset();
    test_retrans();
    test_pause(3);
    test_pause(20);
    test_pause(40);
    test_pause_then_retrans();
    test_remote_pause();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_retrans();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
